// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register with load-use hazard detection, bubble insertion,
// branch/jump flush, global hold and a saturating bubble counter.
package id_ex_pkg;
    localparam logic       DISABLE = 1'b0;
    localparam logic       ENABLE  = 1'b1;
    localparam logic [3:0] ALU_ADD = 4'd2;

    typedef struct packed {
        logic       reg_write;
        logic       memToReg;
        logic       read_mem;
        logic       write_mem;
        logic       branch;
        logic       jmp;
        logic [3:0] ALUop;
        logic       aluSrc;
        logic       reg_dst;
    } dx_ctrl_t;

    localparam dx_ctrl_t BUBBLE = '{
        reg_write: DISABLE, memToReg: DISABLE, read_mem: DISABLE, write_mem: DISABLE,
        branch: DISABLE, jmp: DISABLE, ALUop: ALU_ADD, aluSrc: DISABLE, reg_dst: DISABLE
    };
endpackage

module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  dx_ctrl_t      ctrl_in,
    input  logic          valid_in,
    input  logic [DW-1:0] pc_in,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic [DW-1:0] imm_in,
    input  logic [AW-1:0] rs_in,
    input  logic [AW-1:0] rt_in,
    input  logic [AW-1:0] rd_in,
    input  logic          flush,
    input  logic          hold,
    output dx_ctrl_t      ctrl_out,
    output logic          valid_out,
    output logic [DW-1:0] pc_out,
    output logic [DW-1:0] rs_data_out,
    output logic [DW-1:0] rt_data_out,
    output logic [DW-1:0] imm_out,
    output logic [AW-1:0] rs_out,
    output logic [AW-1:0] rt_out,
    output logic [AW-1:0] rd_out,
    output logic          stall,
    output logic [CW-1:0] bubble_cnt
);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    dx_ctrl_t      ctrl_q, ctrl_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] pc_q, pc_d, rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [AW-1:0] ex_dst;
    logic          load_use;

    // rt_in is compared for every opcode; the occasional false stall is accepted
    assign ex_dst   = ctrl_q.reg_dst ? rd_q : rt_q;
    assign load_use = valid_q & ctrl_q.read_mem & (ex_dst != '0) & valid_in &
                      ((ex_dst == rs_in) | (ex_dst == rt_in));
    assign stall    = load_use & ~flush & ~hold;

    always_comb begin
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        pc_d      = pc_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        if (flush) begin
            // flush outranks hold so a taken branch is never lost
            ctrl_d  = BUBBLE;
            valid_d = 1'b0;
            if (valid_in) cnt_d = sat_inc(cnt_q);
        end else if (hold) begin
            cnt_d = cnt_q;
        end else if (load_use) begin
            ctrl_d  = BUBBLE;
            valid_d = 1'b0;
            cnt_d   = sat_inc(cnt_q);
        end else begin
            ctrl_d    = valid_in ? ctrl_in : BUBBLE;
            valid_d   = valid_in;
            pc_d      = pc_in;
            rs_data_d = rs_data;
            rt_data_d = rt_data;
            imm_d     = imm_in;
            rs_d      = rs_in;
            rt_d      = rt_in;
            rd_d      = rd_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= BUBBLE;
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ctrl_out    = ctrl_q;
    assign valid_out   = valid_q;
    assign pc_out      = pc_q;
    assign rs_data_out = rs_data_q;
    assign rt_data_out = rt_data_q;
    assign imm_out     = imm_q;
    assign rs_out      = rs_q;
    assign rt_out      = rt_q;
    assign rd_out      = rd_q;
    assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instruction stream, monitor pops expected
// EX-stage contents; a second instance with a 2-bit counter covers saturation.
module tb_id_ex_stage;
    import id_ex_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;

    typedef struct packed {
        dx_ctrl_t      ctrl;
        logic [DW-1:0] pc;
        logic [DW-1:0] rsd;
        logic [DW-1:0] rtd;
        logic [DW-1:0] imm;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
    } exp_t;

    localparam dx_ctrl_t EXP_BUBBLE = '{reg_write: 1'b0, memToReg: 1'b0, read_mem: 1'b0,
        write_mem: 1'b0, branch: 1'b0, jmp: 1'b0, ALUop: 4'd2, aluSrc: 1'b0, reg_dst: 1'b0};
    localparam dx_ctrl_t C_ADD = '{reg_write: 1'b1, memToReg: 1'b0, read_mem: 1'b0,
        write_mem: 1'b0, branch: 1'b0, jmp: 1'b0, ALUop: 4'd2, aluSrc: 1'b0, reg_dst: 1'b1};
    localparam dx_ctrl_t C_ADDI = '{reg_write: 1'b1, memToReg: 1'b0, read_mem: 1'b0,
        write_mem: 1'b0, branch: 1'b0, jmp: 1'b0, ALUop: 4'd2, aluSrc: 1'b1, reg_dst: 1'b0};
    localparam dx_ctrl_t C_SW = '{reg_write: 1'b0, memToReg: 1'b0, read_mem: 1'b0,
        write_mem: 1'b1, branch: 1'b0, jmp: 1'b0, ALUop: 4'd2, aluSrc: 1'b1, reg_dst: 1'b0};
    localparam dx_ctrl_t C_LW = '{reg_write: 1'b1, memToReg: 1'b1, read_mem: 1'b1,
        write_mem: 1'b0, branch: 1'b0, jmp: 1'b0, ALUop: 4'd2, aluSrc: 1'b1, reg_dst: 1'b0};

    logic          clk, reset, valid_in, flush, hold;
    dx_ctrl_t      ctrl_in;
    logic [DW-1:0] pc_in, rs_data, rt_data, imm_in;
    logic [AW-1:0] rs_in, rt_in, rd_in;

    dx_ctrl_t      ctrl_out, ctrl_out2;
    logic          valid_out, valid_out2, stall, stall2;
    logic [DW-1:0] pc_out, rs_data_out, rt_data_out, imm_out;
    logic [DW-1:0] pc_out2, rs_data_out2, rt_data_out2, imm_out2;
    logic [AW-1:0] rs_out, rt_out, rd_out, rs_out2, rt_out2, rd_out2;
    logic [CW-1:0] bubble_cnt;
    logic [1:0]    bubble_cnt2;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt  = 0;

    id_ex_stage #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in), .pc_in(pc_in),
        .rs_data(rs_data), .rt_data(rt_data), .imm_in(imm_in), .rs_in(rs_in), .rt_in(rt_in),
        .rd_in(rd_in), .flush(flush), .hold(hold), .ctrl_out(ctrl_out), .valid_out(valid_out),
        .pc_out(pc_out), .rs_data_out(rs_data_out), .rt_data_out(rt_data_out),
        .imm_out(imm_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .stall(stall), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.DW(DW), .AW(AW), .CW(2)) dut_sat (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in), .pc_in(pc_in),
        .rs_data(rs_data), .rt_data(rt_data), .imm_in(imm_in), .rs_in(rs_in), .rt_in(rt_in),
        .rd_in(rd_in), .flush(flush), .hold(hold), .ctrl_out(ctrl_out2), .valid_out(valid_out2),
        .pc_out(pc_out2), .rs_data_out(rs_data_out2), .rt_data_out(rt_data_out2),
        .imm_out(imm_out2), .rs_out(rs_out2), .rt_out(rt_out2), .rd_out(rd_out2),
        .stall(stall2), .bubble_cnt(bubble_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one decode-stage slot; acc=1 means it is expected to reach EX next edge.
    task automatic drive(input dx_ctrl_t c, input logic v, input logic [DW-1:0] pc,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [AW-1:0] rd, input logic fl, input logic hd,
                         input logic acc);
        exp_t e;
        ctrl_in  = c;
        valid_in = v;
        pc_in    = pc;
        rs_data  = pc ^ 32'hA5A5_0000;
        rt_data  = pc ^ 32'h0000_5A5A;
        imm_in   = pc + 32'h100;
        rs_in    = rs;
        rt_in    = rt;
        rd_in    = rd;
        flush    = fl;
        hold     = hd;
        if (acc) begin
            e.ctrl = c;
            e.pc   = pc;
            e.rsd  = pc ^ 32'hA5A5_0000;
            e.rtd  = pc ^ 32'h0000_5A5A;
            e.imm  = pc + 32'h100;
            e.rs   = rs;
            e.rt   = rt;
            e.rd   = rd;
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] sat3(input int n);
        return (n > 3) ? 64'd3 : 64'(n);
    endfunction

    // Monitor: every new real instruction in EX is checked against the scoreboard
    initial begin
        exp_t e, a;
        logic h, f;
        forever begin
            @(posedge clk);
            h = hold;
            f = flush;
            #1;
            if (!reset && !(h && !f) && valid_out) begin
                a.ctrl = ctrl_out;
                a.pc   = pc_out;
                a.rsd  = rs_data_out;
                a.rtd  = rt_data_out;
                a.imm  = imm_out;
                a.rs   = rs_out;
                a.rt   = rt_out;
                a.rd   = rd_out;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL ex_output: unexpected instruction pc=%0h, none expected", pc_out);
                end else begin
                    e = sb.pop_front();
                    if (a !== e) begin
                        failures++;
                        $display("FAIL ex_output: got %0h expected %0h", a, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(C_ADD, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_ctrl", 64'(ctrl_out), 64'(EXP_BUBBLE));
        chk("rst_pc", 64'(pc_out), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_cnt", 64'(bubble_cnt), 64'd0);

        // Passthrough ADD, ADDI, SW
        drive(C_ADD, 1'b1, 32'd4, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
        #1 chk("pass_stall_add", 64'(stall), 64'd0);
        tick();
        chk("pass_latency_pc", 64'(pc_out), 64'd4);
        chk("pass_ctrl_add", 64'(ctrl_out), 64'(C_ADD));
        drive(C_ADDI, 1'b1, 32'd8, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1);
        #1 chk("pass_stall_addi", 64'(stall), 64'd0);
        tick();
        drive(C_SW, 1'b1, 32'd12, 5'd4, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1);
        #1 chk("pass_stall_sw", 64'(stall), 64'd0);
        tick();
        drive(C_ADD, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("idle_valid", 64'(valid_out), 64'd0);
        chk("idle_ctrl_bubble", 64'(ctrl_out), 64'(EXP_BUBBLE));

        // Load-use: LW rt=5 then ADD rs=5
        drive(C_LW, 1'b1, 32'd16, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(C_ADD, 1'b1, 32'd20, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0, 1'b0);
        #1 chk("lu_stall", 64'(stall), 64'd1);
        tick();
        exp_cnt++;
        chk("lu_bubble_valid", 64'(valid_out), 64'd0);
        chk("lu_bubble_ctrl", 64'(ctrl_out), 64'(EXP_BUBBLE));
        chk("lu_stall_drop", 64'(stall), 64'd0);
        chk("lu_cnt", 64'(bubble_cnt), 64'(exp_cnt));
        drive(C_ADD, 1'b1, 32'd20, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0, 1'b1);
        tick();

        // No false stall: r0 destination, and unrelated sources
        drive(C_LW, 1'b1, 32'd24, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(C_ADD, 1'b1, 32'd28, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
        #1 chk("nostall_r0", 64'(stall), 64'd0);
        tick();
        drive(C_LW, 1'b1, 32'd32, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(C_ADD, 1'b1, 32'd36, 5'd6, 5'd7, 5'd8, 1'b0, 1'b0, 1'b1);
        #1 chk("nostall_unrel", 64'(stall), 64'd0);
        tick();

        // Flush together with load-use: one bubble counted
        drive(C_LW, 1'b1, 32'd40, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(C_ADD, 1'b1, 32'd44, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0);
        #1 chk("flush_lu_stall", 64'(stall), 64'd0);
        tick();
        exp_cnt++;
        chk("flush_valid", 64'(valid_out), 64'd0);
        chk("flush_ctrl", 64'(ctrl_out), 64'(EXP_BUBBLE));
        chk("flush_cnt", 64'(bubble_cnt), 64'(exp_cnt));

        // Hold together with flush: flush wins
        drive(C_ADDI, 1'b1, 32'd48, 5'd1, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(C_ADD, 1'b1, 32'd52, 5'd9, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        exp_cnt++;
        chk("holdflush_valid", 64'(valid_out), 64'd0);
        chk("holdflush_cnt", 64'(bubble_cnt), 64'(exp_cnt));

        // Hold 3 cycles with a load in EX and a dependent instruction waiting
        drive(C_LW, 1'b1, 32'd56, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(C_ADD, 1'b1, 32'd60, 5'd5, 5'd2, 5'd6, 1'b0, 1'b1, 1'b0);
            #1 chk("hold_stall", 64'(stall), 64'd0);
            tick();
            chk("hold_pc", 64'(pc_out), 64'd56);
            chk("hold_ctrl", 64'(ctrl_out), 64'(C_LW));
            chk("hold_valid", 64'(valid_out), 64'd1);
            chk("hold_cnt", 64'(bubble_cnt), 64'(exp_cnt));
        end
        drive(C_ADD, 1'b1, 32'd60, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0, 1'b0);
        #1 chk("post_hold_stall", 64'(stall), 64'd1);
        tick();
        exp_cnt++;
        drive(C_ADD, 1'b1, 32'd60, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0, 1'b1);
        tick();
        chk("post_hold_cnt", 64'(bubble_cnt), 64'(exp_cnt));
        chk("sat_pre_reset", 64'(bubble_cnt2), sat3(exp_cnt));

        // Reset asserted mid-stall
        drive(C_LW, 1'b1, 32'd64, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(C_ADD, 1'b1, 32'd68, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0, 1'b0);
        #1 chk("midrst_pre_stall", 64'(stall), 64'd1);
        reset = 1'b1;
        #1;
        exp_cnt = 0;
        chk("midrst_stall", 64'(stall), 64'd0);
        chk("midrst_valid", 64'(valid_out), 64'd0);
        chk("midrst_ctrl", 64'(ctrl_out), 64'(EXP_BUBBLE));
        chk("midrst_pc", 64'(pc_out), 64'd0);
        chk("midrst_imm", 64'(imm_out), 64'd0);
        chk("midrst_rt", 64'(rt_out), 64'd0);
        chk("midrst_cnt", 64'(bubble_cnt), 64'd0);
        chk("midrst_cnt_sat", 64'(bubble_cnt2), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Saturation: five counted flushes on a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            drive(C_ADD, 1'b1, 32'd72, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
            tick();
            exp_cnt++;
            chk("sat_cnt2", 64'(bubble_cnt2), sat3(exp_cnt));
            chk("sat_cnt16", 64'(bubble_cnt), 64'(exp_cnt));
        end
        drive(C_ADD, 1'b0, 32'd76, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        chk("flush_novalid_cnt", 64'(bubble_cnt), 64'(exp_cnt));
        chk("flush_novalid_cnt2", 64'(bubble_cnt2), 64'd3);

        drive(C_ADD, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
